// File: rtl/pv_pkg.sv
// Shared widths, FSM encoding and playfield constants
// for the player/ball physics blocks.
package pv_pkg;

   localparam int POS_W = 11;
   localparam int VEL_W = 10;

   typedef logic signed [POS_W-1:0] pos_t;
   typedef logic signed [VEL_W-1:0] vel_t;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRV1 = 2'd1;
   localparam logic [1:0] S_DRV2 = 2'd2;
   localparam logic [1:0] S_RES  = 2'd3;

   localparam pos_t NET_X = 11'sd400;

   localparam logic P1 = 1'b0;
   localparam logic P2 = 1'b1;

endpackage

// File: rtl/hit_cooldown.sv
// Per-player re-hit cooldown: loaded on a hit,
// stepped down once per resolved round, floors at zero.
module hit_cooldown #(
   parameter int COOLDOWN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   logic [3:0] cnt;

   if (COOLDOWN < 0 || COOLDOWN > 15) begin : g_bad_cd
      $error("COOLDOWN must fit in 4 bits");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= 4'(COOLDOWN);
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/collide_sched.sv
// Time-shares one collide unit between both players
// once per frame and publishes a single ball-velocity hit.
module collide_sched
   import pv_pkg::*;
#(
   parameter int SETTLE   = 5,
   parameter int COOLDOWN = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_tick,
   input  logic signed [POS_W-1:0] p1_x,
   input  logic signed [POS_W-1:0] p1_y,
   input  logic signed [POS_W-1:0] p2_x,
   input  logic signed [POS_W-1:0] p2_y,
   input  logic signed [POS_W-1:0] ball_x,
   input  logic signed [POS_W-1:0] ball_y,
   output logic signed [POS_W-1:0] col_chara_x,
   output logic signed [POS_W-1:0] col_chara_y,
   output logic signed [POS_W-1:0] col_ball_x,
   output logic signed [POS_W-1:0] col_ball_y,
   input  logic signed [VEL_W-1:0] col_vx,
   input  logic signed [VEL_W-1:0] col_vy,
   input  logic                    col_valid,
   output logic                    hit_valid,
   output logic                    hit_player,
   output logic signed [VEL_W-1:0] hit_vx,
   output logic signed [VEL_W-1:0] hit_vy,
   output logic                    busy,
   output logic                    overrun
);

   localparam logic [3:0] LAST = 4'(SETTLE - 1);

   if (SETTLE < 5 || SETTLE > 15) begin : g_bad_settle
      $error("SETTLE must be in 5..15");
   end

   logic [1:0] state;
   logic [3:0] cnt;
   pos_t       l1x, l1y, l2x, l2y, lbx, lby;
   logic       r1_v, r2_v;
   vel_t       r1_vx, r1_vy, r2_vx, r2_vy;
   logic       cd1_zero, cd2_zero;
   logic       res, e1, e2, win, win_p2;
   logic       ld1, ld2, dec1, dec2;

   assign busy = (state != S_IDLE);
   assign res  = (state == S_RES);

   // P1 sits on the collide inputs whenever P2 is not
   assign col_chara_x = (state == S_DRV2) ? l2x : l1x;
   assign col_chara_y = (state == S_DRV2) ? l2y : l1y;
   assign col_ball_x  = lbx;
   assign col_ball_y  = lby;

   assign e1  = r1_v && cd1_zero;
   assign e2  = r2_v && cd2_zero;
   assign win = e1 || e2;
   // double hit goes to whoever owns the ball's side of the net
   assign win_p2 = (e1 && e2) ? (lbx >= NET_X) : e2;

   assign ld1  = res && win && !win_p2;
   assign ld2  = res && win && win_p2;
   assign dec1 = res && !ld1;
   assign dec2 = res && !ld2;

   hit_cooldown #(.COOLDOWN(COOLDOWN)) u_cd1 (
      .clk  (clk),
      .rst  (rst),
      .load (ld1),
      .dec  (dec1),
      .zero (cd1_zero)
   );

   hit_cooldown #(.COOLDOWN(COOLDOWN)) u_cd2 (
      .clk  (clk),
      .rst  (rst),
      .load (ld2),
      .dec  (dec2),
      .zero (cd2_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         l1x        <= '0;
         l1y        <= '0;
         l2x        <= '0;
         l2y        <= '0;
         lbx        <= '0;
         lby        <= '0;
         r1_v       <= 1'b0;
         r1_vx      <= '0;
         r1_vy      <= '0;
         r2_v       <= 1'b0;
         r2_vx      <= '0;
         r2_vy      <= '0;
         hit_valid  <= 1'b0;
         hit_player <= P1;
         hit_vx     <= '0;
         hit_vy     <= '0;
         overrun    <= 1'b0;
      end else begin
         hit_valid <= 1'b0;
         overrun   <= frame_tick && busy;
         case (state)
            S_IDLE: begin
               if (frame_tick) begin
                  l1x   <= p1_x;
                  l1y   <= p1_y;
                  l2x   <= p2_x;
                  l2y   <= p2_y;
                  lbx   <= ball_x;
                  lby   <= ball_y;
                  cnt   <= '0;
                  state <= S_DRV1;
               end
            end
            S_DRV1: begin
               if (cnt == LAST) begin
                  r1_v  <= col_valid;
                  r1_vx <= col_vx;
                  r1_vy <= col_vy;
                  cnt   <= '0;
                  state <= S_DRV2;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_DRV2: begin
               if (cnt == LAST) begin
                  r2_v  <= col_valid;
                  r2_vx <= col_vx;
                  r2_vy <= col_vy;
                  cnt   <= '0;
                  state <= S_RES;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               if (win) begin
                  hit_valid  <= 1'b1;
                  hit_player <= win_p2 ? P2 : P1;
                  hit_vx     <= win_p2 ? r2_vx : r1_vx;
                  hit_vy     <= win_p2 ? r2_vy : r1_vy;
               end
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
